redmule_tile_walker: RTL and testbench

- Consumes the tiled configuration produced by the RedMulE tiler and walks the three-level GEMM loop nest.
- Loop order, outer to inner: X-row block, then W-column block, then reduction over X-column blocks.
- Emits one registered tile descriptor per innermost iteration over a valid/ready handshake, for the streamer and scheduler downstream.
- Precomputes X/Z tile addresses incrementally with adders only (no multipliers), and flags the reduction-last tile as a Z store.

---
 rtl/redmule_tile_walker.sv | 209 ++++++++++++++++++++
 tb/tb_redmule_tile_walker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_tile_walker.sv
// Walks the RedMulE GEMM tile loop nest (X-row block, W-column block, reduction)
// and emits one registered tile descriptor per innermost iteration.
module redmule_tile_walker #(
  parameter int unsigned ARRAY_WIDTH  = 12,
  parameter int unsigned ARRAY_HEIGHT = 4,
  parameter int unsigned PIPE_REGS    = 3,
  parameter int unsigned BITW         = 16,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [15:0]       x_rows_iter_i,
  input  logic [15:0]       w_cols_iter_i,
  input  logic [15:0]       x_cols_iter_i,
  input  logic [7:0]        x_rows_lftovr_i,
  input  logic [7:0]        w_cols_lftovr_i,
  input  logic [7:0]        x_cols_lftovr_i,
  input  logic [ADDR_W-1:0] x_addr_i,
  input  logic [ADDR_W-1:0] z_addr_i,
  input  logic [ADDR_W-1:0] x_rows_offs_i,
  input  logic [ADDR_W-1:0] yz_d2_stride_i,
  output logic              tile_valid_o,
  input  logic              tile_ready_i,
  output logic [15:0]       row_idx_o,
  output logic [15:0]       col_idx_o,
  output logic [15:0]       red_idx_o,
  output logic [7:0]        rows_valid_o,
  output logic [7:0]        cols_valid_o,
  output logic [7:0]        red_valid_o,
  output logic [ADDR_W-1:0] x_tile_addr_o,
  output logic [ADDR_W-1:0] z_tile_addr_o,
  output logic              store_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned       RED_DEPTH  = ARRAY_HEIGHT * (PIPE_REGS + 1);
  localparam logic [ADDR_W-1:0] TILE_BYTES = ADDR_W'(RED_DEPTH * BITW / 8);
  localparam logic [7:0]        ROWS_FULL  = 8'(ARRAY_WIDTH);
  localparam logic [7:0]        RED_FULL   = 8'(RED_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic [15:0]       x_rows_iter;
    logic [15:0]       w_cols_iter;
    logic [15:0]       x_cols_iter;
    logic [7:0]        x_rows_lftovr;
    logic [7:0]        w_cols_lftovr;
    logic [7:0]        x_cols_lftovr;
    logic [ADDR_W-1:0] x_rows_offs;
    logic [ADDR_W-1:0] yz_d2_stride;
  } cfg_t;

  state_e            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic [15:0]       row_q, row_d, col_q, col_d, red_q, red_d;
  logic [ADDR_W-1:0] x_base_q, x_base_d, x_acc_q, x_acc_d;
  logic [ADDR_W-1:0] z_base_q, z_base_d, z_acc_q, z_acc_d;
  logic [7:0]        rows_v_q, rows_v_d, cols_v_q, cols_v_d, red_v_q, red_v_d;
  logic              store_q, store_d, last_q, last_d;

  logic start_fire, zero_cnt, handshake, load_desc;
  logic row_last, col_last, red_last;

  assign zero_cnt   = (x_rows_iter_i == 16'd0) || (w_cols_iter_i == 16'd0) ||
                      (x_cols_iter_i == 16'd0);
  assign start_fire = (state_q == IDLE) && start_i;
  assign handshake  = (state_q == RUN) && tile_ready_i;
  assign load_desc  = (start_fire && !zero_cnt) || handshake;

  assign row_last = (row_q == cfg_q.x_rows_iter - 16'd1);
  assign col_last = (col_q == cfg_q.w_cols_iter - 16'd1);
  assign red_last = (red_q == cfg_q.x_cols_iter - 16'd1);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset and clear share one synchronous path.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) state_q <= IDLE;
    else                    state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = zero_cnt ? DONE : RUN;
      RUN:     if (tile_ready_i && last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs decoded from the state register.
  always_comb begin
    tile_valid_o = (state_q == RUN);
    busy_o       = (state_q == RUN);
    done_o       = (state_q == DONE);
  end

  // Loop-nest advance with incremental address accumulation (adders only).
  always_comb begin
    cfg_d    = cfg_q;
    row_d    = row_q;
    col_d    = col_q;
    red_d    = red_q;
    x_base_d = x_base_q;
    x_acc_d  = x_acc_q;
    z_base_d = z_base_q;
    z_acc_d  = z_acc_q;
    if (start_fire) begin
      cfg_d = '{x_rows_iter:   x_rows_iter_i,   w_cols_iter:   w_cols_iter_i,
                x_cols_iter:   x_cols_iter_i,   x_rows_lftovr: x_rows_lftovr_i,
                w_cols_lftovr: w_cols_lftovr_i, x_cols_lftovr: x_cols_lftovr_i,
                x_rows_offs:   x_rows_offs_i,   yz_d2_stride:  yz_d2_stride_i};
      row_d    = '0;
      col_d    = '0;
      red_d    = '0;
      x_base_d = x_addr_i;
      x_acc_d  = x_addr_i;
      z_base_d = z_addr_i;
      z_acc_d  = z_addr_i;
    end else if (handshake) begin
      if (!red_last) begin
        red_d   = red_q + 16'd1;
        x_acc_d = x_acc_q + TILE_BYTES;
      end else begin
        red_d = '0;
        if (!col_last) begin
          col_d   = col_q + 16'd1;
          x_acc_d = x_base_q;
          z_acc_d = z_acc_q + TILE_BYTES;
        end else begin
          col_d    = '0;
          row_d    = row_q + 16'd1;
          x_base_d = x_base_q + cfg_q.x_rows_offs;
          x_acc_d  = x_base_q + cfg_q.x_rows_offs;
          z_base_d = z_base_q + cfg_q.yz_d2_stride;
          z_acc_d  = z_base_q + cfg_q.yz_d2_stride;
        end
      end
    end
  end

  // Descriptor qualifiers derived from the indices the next tile will carry.
  always_comb begin
    store_d  = (red_d == cfg_d.x_cols_iter - 16'd1);
    last_d   = store_d && (col_d == cfg_d.w_cols_iter - 16'd1) &&
               (row_d == cfg_d.x_rows_iter - 16'd1);
    rows_v_d = ((row_d == cfg_d.x_rows_iter - 16'd1) && (cfg_d.x_rows_lftovr != 8'd0))
               ? cfg_d.x_rows_lftovr : ROWS_FULL;
    cols_v_d = ((col_d == cfg_d.w_cols_iter - 16'd1) && (cfg_d.w_cols_lftovr != 8'd0))
               ? cfg_d.w_cols_lftovr : ROWS_FULL;
    red_v_d  = ((red_d == cfg_d.x_cols_iter - 16'd1) && (cfg_d.x_cols_lftovr != 8'd0))
               ? cfg_d.x_cols_lftovr : RED_FULL;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      cfg_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      red_q    <= '0;
      x_base_q <= '0;
      x_acc_q  <= '0;
      z_base_q <= '0;
      z_acc_q  <= '0;
      rows_v_q <= '0;
      cols_v_q <= '0;
      red_v_q  <= '0;
      store_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      if (start_fire) cfg_q <= cfg_d;
      // Descriptor only moves on a fresh start or an accepted tile, so it holds under stall.
      if (load_desc) begin
        row_q    <= row_d;
        col_q    <= col_d;
        red_q    <= red_d;
        x_base_q <= x_base_d;
        x_acc_q  <= x_acc_d;
        z_base_q <= z_base_d;
        z_acc_q  <= z_acc_d;
        rows_v_q <= rows_v_d;
        cols_v_q <= cols_v_d;
        red_v_q  <= red_v_d;
        store_q  <= store_d;
        last_q   <= last_d;
      end
    end
  end

  assign row_idx_o     = row_q;
  assign col_idx_o     = col_q;
  assign red_idx_o     = red_q;
  assign rows_valid_o  = rows_v_q;
  assign cols_valid_o  = cols_v_q;
  assign red_valid_o   = red_v_q;
  assign x_tile_addr_o = x_acc_q;
  assign z_tile_addr_o = z_acc_q;
  assign store_o       = store_q;
  assign last_o        = last_q;

endmodule

// File: tb/tb_redmule_tile_walker.sv
// Directed self-checking bench for redmule_tile_walker: reset, single tile,
// leftovers, addresses, wrap, backpressure, zero count, abort and mid-run reset.
module tb_redmule_tile_walker;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] x_rows_iter_i = '0, w_cols_iter_i = '0, x_cols_iter_i = '0;
  logic [7:0]  x_rows_lftovr_i = '0, w_cols_lftovr_i = '0, x_cols_lftovr_i = '0;
  logic [31:0] x_addr_i = '0, z_addr_i = '0, x_rows_offs_i = '0, yz_d2_stride_i = '0;
  logic        tile_valid_o, tile_ready_i = 1'b0;
  logic [15:0] row_idx_o, col_idx_o, red_idx_o;
  logic [7:0]  rows_valid_o, cols_valid_o, red_valid_o;
  logic [31:0] x_tile_addr_o, z_tile_addr_o;
  logic        store_o, last_o, busy_o, done_o;

  int checks = 0;
  int failures = 0;

  redmule_tile_walker dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .x_rows_iter_i(x_rows_iter_i), .w_cols_iter_i(w_cols_iter_i), .x_cols_iter_i(x_cols_iter_i),
    .x_rows_lftovr_i(x_rows_lftovr_i), .w_cols_lftovr_i(w_cols_lftovr_i),
    .x_cols_lftovr_i(x_cols_lftovr_i), .x_addr_i(x_addr_i), .z_addr_i(z_addr_i),
    .x_rows_offs_i(x_rows_offs_i), .yz_d2_stride_i(yz_d2_stride_i),
    .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
    .row_idx_o(row_idx_o), .col_idx_o(col_idx_o), .red_idx_o(red_idx_o),
    .rows_valid_o(rows_valid_o), .cols_valid_o(cols_valid_o), .red_valid_o(red_valid_o),
    .x_tile_addr_o(x_tile_addr_o), .z_tile_addr_o(z_tile_addr_o),
    .store_o(store_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cfg(input int xr, input int wc, input int xc,
                         input int lr, input int lc, input int lx,
                         input logic [31:0] xa, input logic [31:0] za,
                         input logic [31:0] offs, input logic [31:0] stride);
    x_rows_iter_i = 16'(xr);  w_cols_iter_i = 16'(wc);  x_cols_iter_i = 16'(xc);
    x_rows_lftovr_i = 8'(lr); w_cols_lftovr_i = 8'(lc); x_cols_lftovr_i = 8'(lx);
    x_addr_i = xa; z_addr_i = za; x_rows_offs_i = offs; yz_d2_stride_i = stride;
  endtask

  task automatic check_tile(input string tag, input int r, input int c, input int n,
                            input int rows, input int cols, input int red,
                            input bit store, input bit last,
                            input logic [31:0] xa, input logic [31:0] za);
    check({tag, ".valid"}, 32'(tile_valid_o), 32'd1);
    check({tag, ".row"},   32'(row_idx_o), 32'(r));
    check({tag, ".col"},   32'(col_idx_o), 32'(c));
    check({tag, ".red"},   32'(red_idx_o), 32'(n));
    check({tag, ".rowsv"}, 32'(rows_valid_o), 32'(rows));
    check({tag, ".colsv"}, 32'(cols_valid_o), 32'(cols));
    check({tag, ".redv"},  32'(red_valid_o), 32'(red));
    check({tag, ".store"}, 32'(store_o), 32'(store));
    check({tag, ".last"},  32'(last_o), 32'(last));
    check({tag, ".xaddr"}, x_tile_addr_o, xa);
    check({tag, ".zaddr"}, z_tile_addr_o, za);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, 32'(tile_valid_o), 32'd0);
    check({tag, ".busy"},  32'(busy_o), 32'd0);
    check({tag, ".done"},  32'(done_o), 32'd0);
    check({tag, ".row"},   32'(row_idx_o), 32'd0);
    check({tag, ".col"},   32'(col_idx_o), 32'd0);
    check({tag, ".red"},   32'(red_idx_o), 32'd0);
    check({tag, ".rowsv"}, 32'(rows_valid_o), 32'd0);
    check({tag, ".colsv"}, 32'(cols_valid_o), 32'd0);
    check({tag, ".redv"},  32'(red_valid_o), 32'd0);
    check({tag, ".xaddr"}, x_tile_addr_o, 32'd0);
    check({tag, ".zaddr"}, z_tile_addr_o, 32'd0);
    check({tag, ".store"}, 32'(store_o), 32'd0);
    check({tag, ".last"},  32'(last_o), 32'd0);
  endtask

  initial begin
    int k;
    int dones;
    bit stalled;
    logic [31:0] snap_x;

    // Reset state
    tick(); tick();
    check_zero("reset");
    rst_ni = 1'b1;
    tick();
    check_zero("post_reset");

    // Single tile: descriptor at cycle 1, done at cycle 2
    set_cfg(1, 1, 1, 0, 0, 0, 32'h1000, 32'h2000, 32'h300, 32'h180);
    tile_ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_tile("single", 0, 0, 0, 12, 12, 16, 1, 1, 32'h1000, 32'h2000);
    check("single.busy", 32'(busy_o), 32'd1);
    tick();
    check("single.done", 32'(done_o), 32'd1);
    check("single.valid_off", 32'(tile_valid_o), 32'd0);
    check("single.busy_off", 32'(busy_o), 32'd0);
    tick();
    check("single.done_once", 32'(done_o), 32'd0);

    // Leftovers: 3x2x2 with partial last blocks
    set_cfg(3, 2, 2, 1, 4, 5, 32'h1000, 32'h2000, 32'h200, 32'h100);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 2; c++)
        for (int n = 0; n < 2; n++) begin
          check_tile("lftovr", r, c, n, (r == 2) ? 1 : 12, (c == 1) ? 4 : 12,
                     (n == 1) ? 5 : 16, n == 1, (r == 2) && (c == 1) && (n == 1),
                     32'h1000 + 32'(r) * 32'h200 + 32'(n) * 32'h20,
                     32'h2000 + 32'(r) * 32'h100 + 32'(c) * 32'h20);
          tick();
        end
    check("lftovr.done", 32'(done_o), 32'd1);
    tick();

    // Addresses: 2x2x3, last tile is (r1,c1,n2)
    set_cfg(2, 2, 3, 0, 0, 0, 32'h4000, 32'h8000, 32'h300, 32'h180);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        for (int n = 0; n < 3; n++) begin
          check_tile("addr", r, c, n, 12, 12, 16, n == 2, (r == 1) && (c == 1) && (n == 2),
                     32'h4000 + 32'(r) * 32'h300 + 32'(n) * 32'h20,
                     32'h8000 + 32'(r) * 32'h180 + 32'(c) * 32'h20);
          if (r == 1 && c == 1 && n == 2) begin
            check("addr.r1c1n2.x", x_tile_addr_o, 32'h4340);
            check("addr.r1c1n2.z", z_tile_addr_o, 32'h81A0);
          end
          tick();
        end
    check("addr.done", 32'(done_o), 32'd1);
    tick();

    // Address arithmetic wraps modulo 2^32
    set_cfg(1, 1, 2, 0, 0, 0, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("wrap.x0", x_tile_addr_o, 32'hFFFF_FFF0);
    tick();
    check("wrap.x1", x_tile_addr_o, 32'h0000_0010);
    check("wrap.last", 32'(last_o), 32'd1);
    tick();
    check("wrap.done", 32'(done_o), 32'd1);
    tick();

    // Backpressure: random ready, descriptors must hold while stalled
    set_cfg(2, 1, 2, 0, 0, 0, 32'h100, 32'h200, 32'h40, 32'h80);
    tile_ready_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    k = 0;
    dones = 0;
    stalled = 1'b0;
    snap_x = '0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      tile_ready_i = (cyc >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
      if (tile_valid_o) begin
        if (k >= 4) begin
          check("bp.extra_valid", 32'(tile_valid_o), 32'd0);
        end else begin
          check_tile("bp", k / 2, 0, k % 2, 12, 12, 16, (k % 2) == 1, k == 3,
                     32'h100 + 32'(k / 2) * 32'h40 + 32'(k % 2) * 32'h20,
                     32'h200 + 32'(k / 2) * 32'h80);
          if (stalled) check("bp.hold_x", x_tile_addr_o, snap_x);
        end
        stalled = !tile_ready_i;
        snap_x = x_tile_addr_o;
        if (tile_ready_i) k++;
      end
      if (done_o) dones++;
      tick();
    end
    check("bp.handshakes", 32'(k), 32'd4);
    check("bp.dones", 32'(dones), 32'd1);

    // Zero count: no tiles, done the cycle after start
    set_cfg(2, 0, 2, 0, 0, 0, 32'h100, 32'h200, 32'h40, 32'h80);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("zero.valid", 32'(tile_valid_o), 32'd0);
    check("zero.busy", 32'(busy_o), 32'd0);
    check("zero.done", 32'(done_o), 32'd1);
    tick();
    check("zero.done_once", 32'(done_o), 32'd0);

    // Abort with clear_i on the 5th tile, start_i on the same cycle ignored
    set_cfg(2, 2, 2, 0, 0, 0, 32'h5000, 32'h6000, 32'h100, 32'h80);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick(); tick();
    check_tile("abort.t5", 1, 0, 0, 12, 12, 16, 0, 0, 32'h5100, 32'h6080);
    clear_i = 1'b1;
    start_i = 1'b1;
    tick();
    clear_i = 1'b0;
    start_i = 1'b0;
    check_zero("abort.cleared");
    tick();
    check("abort.no_done", 32'(done_o), 32'd0);
    check("abort.idle", 32'(tile_valid_o), 32'd0);
    set_cfg(1, 1, 2, 0, 0, 0, 32'h9000, 32'hA000, 32'h0, 32'h0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_tile("restart", 0, 0, 0, 12, 12, 16, 0, 0, 32'h9000, 32'hA000);
    tick(); tick();
    check("restart.done", 32'(done_o), 32'd1);
    tick();

    // Reset mid-RUN clears everything on the next edge
    set_cfg(2, 2, 2, 0, 0, 0, 32'h7000, 32'h7800, 32'h100, 32'h80);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    check("rst_mid.busy_before", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    tick();
    check_zero("rst_mid");
    rst_ni = 1'b1;
    tick();
    check("rst_mid.stays_idle", 32'(tile_valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
